// File: rtl/data_mem_responder_if.sv
// Request/response bus between the CPU core and its data/instruction memory.
// Separate valid/ready handshakes on the request and response channels.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding bus-slave memory with a fixed number of wait states
// between request accept and response.
module data_mem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wstrb;
    logic        rsp_valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [0:(1 << ADDR_W) - 1];

    logic              access;
    logic              acc_err;
    logic [ADDR_W-1:0] idx;

    assign idx     = lat_addr[ADDR_W+1:2];
    assign acc_err = (lat_addr[1:0] != 2'b00) || (lat_addr[31:ADDR_W+2] != '0);
    assign access  = !rst && (state == WAIT) && (cnt == '0);

    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_we    <= bus.req_we;
                        lat_addr  <= bus.req_addr;
                        lat_wdata <= bus.req_wdata;
                        lat_wstrb <= bus.req_wstrb;
                        cnt       <= 4'(LATENCY);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Writes and faulting accesses return zero data.
                        rdata_q     <= (acc_err || lat_we) ? '0 : mem[idx];
                        err_q       <= acc_err;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage has no reset; a write only lands on its access edge.
    always_ff @(posedge clk) begin
        if (access && lat_we && !acc_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lat_wstrb[i]) mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
            end
        end
    end
endmodule
